eth_rx_mac_filter: RTL and testbench

- Destination-MAC filter directly downstream of the 1G MAC RX FIFO output, in the logic clock domain.
- Consumes 8-bit AXI-stream Ethernet frames with FCS already stripped and tuser marking bad frames.
- Inspects the 6-byte destination address and forwards or discards each whole frame.
- Forwarded frames are byte-identical; discarded frames are consumed at full rate with no output.

---
 rtl/eth_rx_mac_filter_pkg.sv | 15 +
 rtl/eth_rx_mac_filter_match.sv | 19 +
 rtl/eth_rx_mac_filter.sv | 207 ++++++++++++++++++++
 tb/tb_eth_rx_mac_filter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_mac_filter_pkg.sv
// Shared types and constants for the receive-side destination-MAC filter.
package eth_rx_mac_filter_pkg;

    typedef enum logic [1:0] {
        HDR,
        HDR_OUT,
        PASS,
        DROP
    } state_t;

    localparam logic [47:0] MAC_BCAST = 48'hffff_ffff_ffff;
    localparam int          HDR_LEN   = 6;
    localparam logic [2:0]  HDR_LAST  = 3'(HDR_LEN - 1);

endpackage

// File: rtl/eth_rx_mac_filter_match.sv
// Destination-address acceptance test against the per-frame latched configuration.
module eth_rx_mac_filter_match
    import eth_rx_mac_filter_pkg::*;
(
    input  logic [47:0] da,
    input  logic [47:0] local_mac,
    input  logic        promisc_en,
    input  logic        bcast_en,
    input  logic        mcast_en,
    output logic        match
);

    // da[40] is the group bit of the first byte on the wire
    assign match = promisc_en
                 | (da == local_mac)
                 | (bcast_en & (da == MAC_BCAST))
                 | (mcast_en & da[40]);

endmodule

// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC filter for 8-bit AXI-stream frames from the MAC RX FIFO.
// Buffers the 6-byte destination address, then forwards or discards the frame.
// Optional statistics counters are enabled with `define ETH_RX_MAC_FILTER_STATS_EN.
module eth_rx_mac_filter
    import eth_rx_mac_filter_pkg::*;
#(
    parameter bit DROP_RUNT  = 1'b1,
    parameter int STAT_WIDTH = 32
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic [47:0] local_mac,
    input  logic        promisc_en,
    input  logic        bcast_en,
    input  logic        mcast_en,
    output logic        frame_pass,
    output logic        frame_drop
`ifdef ETH_RX_MAC_FILTER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_pass_count,
    output logic [STAT_WIDTH-1:0] stat_drop_count
`endif
);

    state_t      state;
    logic        active;
    logic [2:0]  idx;
    logic [2:0]  out_idx;
    logic [2:0]  last_idx;
    logic        runt;
    logic [7:0]  hdr_buf [HDR_LEN];
    logic [47:0] cfg_mac;
    logic        cfg_promisc;
    logic        cfg_bcast;
    logic        cfg_mcast;
    logic [47:0] da;
    logic        match;
    logic        ready_c;
    logic        s_fire;
    logic        out_free;

    // A zero-width stats counter would be meaningless; reject it at elaboration time
    if (STAT_WIDTH < 1) begin : g_stat_width_invalid
        initial_width_check_failed_stat_width_must_be_positive u_bad ();
    end

    // The sixth address byte is still on the input bus during the decision cycle
    assign da = {hdr_buf[0], hdr_buf[1], hdr_buf[2], hdr_buf[3], hdr_buf[4], s_axis_tdata};

    eth_rx_mac_filter_match u_match (
        .da         (da),
        .local_mac  (cfg_mac),
        .promisc_en (cfg_promisc),
        .bcast_en   (cfg_bcast),
        .mcast_en   (cfg_mcast),
        .match      (match)
    );

    assign out_free = m_axis_tready | ~m_axis_tvalid;

    // Input ready per state; held low until the first cycle after reset
    always_comb begin
        ready_c = 1'b0;
        if (active) begin
            unique case (state)
                HDR:     ready_c = 1'b1;
                HDR_OUT: ready_c = 1'b0;
                PASS:    ready_c = out_free;
                DROP:    ready_c = 1'b1;
                default: ready_c = 1'b0;
            endcase
        end
    end

    assign s_axis_tready = ready_c;
    assign s_fire        = s_axis_tvalid & ready_c;

    // Frame FSM together with the header buffer and the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= HDR;
            active        <= 1'b0;
            idx           <= '0;
            out_idx       <= '0;
            last_idx      <= '0;
            runt          <= 1'b0;
            cfg_mac       <= '0;
            cfg_promisc   <= 1'b0;
            cfg_bcast     <= 1'b0;
            cfg_mcast     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_pass    <= 1'b0;
            frame_drop    <= 1'b0;
            for (int i = 0; i < HDR_LEN; i++) begin
                hdr_buf[i] <= '0;
            end
        end else begin
            active     <= 1'b1;
            frame_pass <= 1'b0;
            frame_drop <= 1'b0;
            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            unique case (state)
                HDR: begin
                    if (s_fire) begin
                        hdr_buf[idx] <= s_axis_tdata;
                        if (idx == 3'd0) begin
                            cfg_mac     <= local_mac;
                            cfg_promisc <= promisc_en;
                            cfg_bcast   <= bcast_en;
                            cfg_mcast   <= mcast_en;
                        end
                        if (s_axis_tlast) begin
                            idx <= '0;
                            if (DROP_RUNT) begin
                                frame_drop <= 1'b1;
                            end else begin
                                frame_pass <= 1'b1;
                                runt       <= 1'b1;
                                last_idx   <= idx;
                                out_idx    <= '0;
                                state      <= HDR_OUT;
                            end
                        end else if (idx == HDR_LAST) begin
                            idx      <= '0;
                            runt     <= 1'b0;
                            last_idx <= HDR_LAST;
                            out_idx  <= '0;
                            if (match) begin
                                frame_pass <= 1'b1;
                                state      <= HDR_OUT;
                            end else begin
                                frame_drop <= 1'b1;
                                state      <= DROP;
                            end
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                HDR_OUT: begin
                    if (out_free) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= hdr_buf[out_idx];
                        m_axis_tlast  <= runt && (out_idx == last_idx);
                        m_axis_tuser  <= runt && (out_idx == last_idx);
                        if (out_idx == last_idx) begin
                            state <= runt ? HDR : PASS;
                        end else begin
                            out_idx <= out_idx + 3'd1;
                        end
                    end
                end
                PASS: begin
                    if (s_fire) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tlast  <= s_axis_tlast;
                        m_axis_tuser  <= s_axis_tlast & s_axis_tuser;
                        if (s_axis_tlast) begin
                            state <= HDR;
                        end
                    end
                end
                DROP: begin
                    if (s_fire && s_axis_tlast) begin
                        state <= HDR;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

`ifdef ETH_RX_MAC_FILTER_STATS_EN
    // Saturating counts of pass and drop decisions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pass_count <= '0;
            stat_drop_count <= '0;
        end else begin
            if (frame_pass && (stat_pass_count != '1)) begin
                stat_pass_count <= stat_pass_count + 1'b1;
            end
            if (frame_drop && (stat_drop_count != '1)) begin
                stat_drop_count <= stat_drop_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed and randomised checks of eth_rx_mac_filter, with a second instance built
// with DROP_RUNT=0 to observe runt forwarding. Stats ports follow ETH_RX_MAC_FILTER_STATS_EN.
module tb_eth_rx_mac_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tuser;
    logic        s_axis_tready, s_ready_r0;
    logic [7:0]  m_axis_tdata, m_tdata_r0;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic        m_valid_r0, m_last_r0, m_user_r0;
    logic        m_axis_tready;
    logic [47:0] local_mac;
    logic        promisc_en, bcast_en, mcast_en;
    logic        frame_pass, frame_drop, pass_r0, drop_r0;
`ifdef ETH_RX_MAC_FILTER_STATS_EN
    logic [31:0] stat_pass_count, stat_drop_count, stat_pass_r0, stat_drop_r0;
`endif

    logic [7:0]  frm[$];
    logic [9:0]  got[$];
    logic [9:0]  got_r0[$];
    logic [9:0]  exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          pass_cnt = 0;
    int          drop_cnt = 0;
    int          stall_err = 0;
    bit          rand_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_word = '0;

    always #5 clk = ~clk;

    eth_rx_mac_filter #(.DROP_RUNT(1'b1), .STAT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .local_mac(local_mac), .promisc_en(promisc_en), .bcast_en(bcast_en), .mcast_en(mcast_en),
        .frame_pass(frame_pass), .frame_drop(frame_drop)
`ifdef ETH_RX_MAC_FILTER_STATS_EN
        , .stat_pass_count(stat_pass_count), .stat_drop_count(stat_drop_count)
`endif
    );

    eth_rx_mac_filter #(.DROP_RUNT(1'b0), .STAT_WIDTH(32)) dut_r0 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_ready_r0),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_tdata_r0), .m_axis_tvalid(m_valid_r0), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_last_r0), .m_axis_tuser(m_user_r0),
        .local_mac(local_mac), .promisc_en(promisc_en), .bcast_en(bcast_en), .mcast_en(mcast_en),
        .frame_pass(pass_r0), .frame_drop(drop_r0)
`ifdef ETH_RX_MAC_FILTER_STATS_EN
        , .stat_pass_count(stat_pass_r0), .stat_drop_count(stat_drop_r0)
`endif
    );

    // Downstream ready: always 1, or a coin flip each cycle in random mode
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor on the falling edge: collect beats, count pulses, watch stall stability
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_pass) pass_cnt++;
            if (frame_drop) drop_cnt++;
            if (prev_stall && (!m_axis_tvalid || ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== prev_word)))
                stall_err++;
            if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            if (m_valid_r0 && m_axis_tready) got_r0.push_back({m_user_r0, m_last_r0, m_tdata_r0});
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        end
    end

    function automatic bit exp_match(input logic [47:0] da, input logic [47:0] mac,
                                     input logic pr, input logic bc, input logic mc);
        return pr || (da == mac) || (bc && da == 48'hffffffffffff) || (mc && da[40]);
    endfunction

    function automatic int diff_got_exp();
        int d = (got.size() > exp_q.size()) ? got.size() - exp_q.size() : exp_q.size() - got.size();
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic build_frame(input logic [47:0] da, input int len);
        frm.delete();
        for (int i = 0; i < len; i++)
            frm.push_back(i < 6 ? da[47 - 8*i -: 8] : 8'(i * 7 + len));
    endtask

    task automatic push_expected(input logic user);
        for (int i = 0; i < frm.size(); i++)
            exp_q.push_back({(i == frm.size() - 1) ? user : 1'b0, i == frm.size() - 1, frm[i]});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int flip_at, input logic user, output int stalls);
        int to;
        stalls = 0;
        for (int i = 0; i < frm.size(); i++) begin
            s_axis_tdata  = frm[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == frm.size() - 1);
            s_axis_tuser  = (i == frm.size() - 1) ? user : 1'b0;
            to = 0;
            @(negedge clk);
            while (!s_axis_tready && to < 4000) begin
                stalls++;
                to++;
                @(negedge clk);
            end
            if (to >= 4000) begin
                checks++;
                $display("[TB] FAIL input_timeout: s_axis_tready stuck at %0b, required 1", s_axis_tready);
                s_axis_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (i == flip_at) promisc_en = 1'b1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (s_axis_tready !== 1'b0) $display("[TB] FAIL rst_s_tready: got %0b want 0", s_axis_tready); else passes++;
        checks++; if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL rst_m_tvalid: got %0b want 0", m_axis_tvalid); else passes++;
        checks++; if (m_axis_tdata !== 8'h00) $display("[TB] FAIL rst_m_tdata: got %0h want 0", m_axis_tdata); else passes++;
        checks++; if (m_axis_tlast !== 1'b0) $display("[TB] FAIL rst_m_tlast: got %0b want 0", m_axis_tlast); else passes++;
        checks++; if (m_axis_tuser !== 1'b0) $display("[TB] FAIL rst_m_tuser: got %0b want 0", m_axis_tuser); else passes++;
        checks++; if (frame_pass !== 1'b0) $display("[TB] FAIL rst_frame_pass: got %0b want 0", frame_pass); else passes++;
        checks++; if (frame_drop !== 1'b0) $display("[TB] FAIL rst_frame_drop: got %0b want 0", frame_drop); else passes++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_unicast_pass();
        int st, p0, d0, df;
        got.delete(); exp_q.delete(); p0 = pass_cnt; d0 = drop_cnt;
        build_frame(48'h02_00_00_00_00_01, 64);
        send_frame(-1, 1'b0, st);
        push_expected(1'b0);
        idle(10);
        df = diff_got_exp();
        checks++; if (df !== 0) $display("[TB] FAIL uc_pass_data: got %0d beats (%0d diffs), want 64", got.size(), df); else passes++;
        checks++; if (pass_cnt - p0 !== 1) $display("[TB] FAIL uc_pass_pulse: got %0d want 1", pass_cnt - p0); else passes++;
        checks++; if (drop_cnt - d0 !== 0) $display("[TB] FAIL uc_pass_nodrop: got %0d want 0", drop_cnt - d0); else passes++;
        checks++; if (st !== 6) $display("[TB] FAIL uc_pass_stall: got %0d want 6", st); else passes++;
    endtask

    task automatic test_unicast_drop();
        int st, p0, d0;
        got.delete(); p0 = pass_cnt; d0 = drop_cnt;
        build_frame(48'h02_00_00_00_00_02, 64);
        send_frame(-1, 1'b0, st);
        idle(10);
        checks++; if (got.size() !== 0) $display("[TB] FAIL uc_drop_out: got %0d beats want 0", got.size()); else passes++;
        checks++; if (drop_cnt - d0 !== 1) $display("[TB] FAIL uc_drop_pulse: got %0d want 1", drop_cnt - d0); else passes++;
        checks++; if (pass_cnt - p0 !== 0) $display("[TB] FAIL uc_drop_nopass: got %0d want 0", pass_cnt - p0); else passes++;
        checks++; if (st !== 0) $display("[TB] FAIL uc_drop_ready: got %0d stall cycles want 0", st); else passes++;
    endtask

    task automatic test_bcast_mcast();
        int st, p0, d0, df;
        got.delete(); exp_q.delete(); p0 = pass_cnt; d0 = drop_cnt;
        bcast_en = 1'b0;
        build_frame(48'hff_ff_ff_ff_ff_ff, 20);
        send_frame(-1, 1'b0, st);
        idle(5);
        bcast_en = 1'b1;
        send_frame(-1, 1'b1, st);
        push_expected(1'b1);
        idle(5);
        mcast_en = 1'b1;
        build_frame(48'h01_00_5e_00_00_01, 30);
        send_frame(-1, 1'b0, st);
        push_expected(1'b0);
        idle(10);
        df = diff_got_exp();
        checks++; if (df !== 0) $display("[TB] FAIL bc_mc_data: got %0d beats (%0d diffs) want %0d", got.size(), df, exp_q.size()); else passes++;
        checks++; if (drop_cnt - d0 !== 1) $display("[TB] FAIL bc_mc_drops: got %0d want 1", drop_cnt - d0); else passes++;
        checks++; if (pass_cnt - p0 !== 2) $display("[TB] FAIL bc_mc_passes: got %0d want 2", pass_cnt - p0); else passes++;
        bcast_en = 1'b0;
        mcast_en = 1'b0;
    endtask

    task automatic test_runt();
        int st, d0, df;
        logic [9:0] exp_r0[$];
        got.delete(); got_r0.delete(); d0 = drop_cnt;
        build_frame(48'h02_00_00_00_00_01, 4);
        send_frame(-1, 1'b0, st);
        for (int i = 0; i < 4; i++) exp_r0.push_back({i == 3, i == 3, frm[i]});
        idle(15);
        build_frame(48'h02_00_00_00_00_01, 6);
        send_frame(-1, 1'b0, st);
        for (int i = 0; i < 6; i++) exp_r0.push_back({i == 5, i == 5, frm[i]});
        idle(15);
        df = (got_r0.size() == exp_r0.size()) ? 0 : 1;
        for (int i = 0; i < got_r0.size() && i < exp_r0.size(); i++)
            if (got_r0[i] !== exp_r0[i]) df++;
        checks++; if (got.size() !== 0) $display("[TB] FAIL runt_drop_out: got %0d beats want 0", got.size()); else passes++;
        checks++; if (drop_cnt - d0 !== 2) $display("[TB] FAIL runt_drop_pulse: got %0d want 2", drop_cnt - d0); else passes++;
        checks++; if (df !== 0) $display("[TB] FAIL runt_fwd_data: got %0d beats (%0d diffs) want 10", got_r0.size(), df); else passes++;
    endtask

    task automatic test_config_change();
        int st, p0, d0;
        got.delete(); p0 = pass_cnt; d0 = drop_cnt;
        promisc_en = 1'b0;
        build_frame(48'h02_00_00_00_00_02, 40);
        send_frame(2, 1'b0, st);
        idle(10);
        promisc_en = 1'b0;
        checks++; if (got.size() !== 0) $display("[TB] FAIL cfg_change_out: got %0d beats want 0", got.size()); else passes++;
        checks++; if (drop_cnt - d0 !== 1 || pass_cnt - p0 !== 0)
            $display("[TB] FAIL cfg_change_pulse: got drop %0d pass %0d want 1/0", drop_cnt - d0, pass_cnt - p0); else passes++;
    endtask

    task automatic test_back_to_back();
        int st, p0, d0, df, ep, ed, to, len, kind;
        logic [47:0] da;
        logic user;
        got.delete(); exp_q.delete(); p0 = pass_cnt; d0 = drop_cnt; ep = 0; ed = 0;
        rand_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            kind = $urandom_range(0, 3);
            da = (kind == 0) ? 48'h02_00_00_00_00_01 : (kind == 1) ? 48'h02_00_00_00_00_07 :
                 (kind == 2) ? 48'hff_ff_ff_ff_ff_ff : 48'h01_00_5e_00_00_2a;
            len = (f == 0) ? 60 : (f == 99) ? 1514 : $urandom_range(60, 300);
            user = ($urandom_range(0, 3) == 0);
            promisc_en = ($urandom_range(0, 7) == 0);
            bcast_en = 1'($urandom_range(0, 1));
            mcast_en = 1'($urandom_range(0, 1));
            build_frame(da, len);
            if (exp_match(da, local_mac, promisc_en, bcast_en, mcast_en)) begin
                push_expected(user);
                ep++;
            end else ed++;
            send_frame(-1, user, st);
        end
        to = 0;
        while (got.size() < exp_q.size() && to < 5000) begin
            @(posedge clk);
            to++;
        end
        rand_ready = 1'b0;
        idle(5);
        df = diff_got_exp();
        checks++; if (df !== 0) $display("[TB] FAIL b2b_stream: got %0d beats (%0d diffs) want %0d", got.size(), df, exp_q.size()); else passes++;
        checks++; if (pass_cnt - p0 !== ep) $display("[TB] FAIL b2b_passes: got %0d want %0d", pass_cnt - p0, ep); else passes++;
        checks++; if (drop_cnt - d0 !== ed) $display("[TB] FAIL b2b_drops: got %0d want %0d", drop_cnt - d0, ed); else passes++;
        checks++; if (stall_err !== 0) $display("[TB] FAIL b2b_stall_stable: got %0d violations want 0", stall_err); else passes++;
        promisc_en = 1'b0;
        bcast_en = 1'b0;
        mcast_en = 1'b0;
    endtask

`ifdef ETH_RX_MAC_FILTER_STATS_EN
    task automatic test_stats();
        idle(3);
        checks++; if (stat_pass_count !== 32'(pass_cnt)) $display("[TB] FAIL stat_pass: got %0d want %0d", stat_pass_count, pass_cnt); else passes++;
        checks++; if (stat_drop_count !== 32'(drop_cnt)) $display("[TB] FAIL stat_drop: got %0d want %0d", stat_drop_count, drop_cnt); else passes++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        local_mac = 48'h02_00_00_00_00_01;
        promisc_en = 1'b0; bcast_en = 1'b0; mcast_en = 1'b0;
        test_reset();
        test_unicast_pass();
        test_unicast_drop();
        test_bcast_mcast();
        test_runt();
        test_config_change();
        test_back_to_back();
`ifdef ETH_RX_MAC_FILTER_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
